// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Register offsets from BASE_ADDR
  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_STATUS = 1;

  // Status register bit positions
  localparam int unsigned STAT_FULL = 0;
  localparam int unsigned STAT_IDLE = 1;
  localparam int unsigned STAT_OVR  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a status register.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | line high, waiting for the FIFO to hold a byte
//   ST_START | start bit (line low) for CLKS_PER_BIT cycles
//   ST_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_STOP  | stop bit (line high), then next byte or idle
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h0F00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [15:0]   ADDR_DATA  = BASE_ADDR + 16'(REG_DATA);
  localparam logic [15:0]   ADDR_STAT  = BASE_ADDR + 16'(REG_STATUS);

  tx_state_e      state, state_nxt;
  logic [CW-1:0]  bit_cnt, cnt_nxt;
  logic [2:0]     bit_idx, idx_nxt;
  logic [7:0]     shreg, sh_nxt;
  logic           tx_nxt;
  logic           busy_nxt;
  logic           overrun;

  logic           wr_hit;
  logic           rd_stat_hit;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [7:0]     fifo_dout;
  logic [7:0]     status;

  assign wr_hit      = !i_rw && (i_addr == ADDR_DATA);
  assign rd_stat_hit =  i_rw && (i_addr == ADDR_STAT);
  // Full is the registered count, so a pop on the same edge does not rescue a write.
  assign fifo_push   = wr_hit && !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (i_data),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Status word presented to the CPU.
  always_comb begin
    status            = 8'h00;
    status[STAT_FULL] = fifo_full;
    status[STAT_IDLE] = fifo_empty && (state == ST_IDLE);
    status[STAT_OVR]  = overrun;
  end

  assign o_data = rd_stat_hit ? status : 8'h00;

  // Sticky overrun: a dropped write wins over a clearing status read on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= 1'b0;
    end else if (wr_hit && fifo_full) begin
      overrun <= 1'b1;
    end else if (rd_stat_hit) begin
      overrun <= 1'b0;
    end
  end

  // Next-state, bit timing, shifter and registered-output values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    fifo_pop  = 1'b0;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b0;

    if (bit_cnt != '0) begin
      cnt_nxt = bit_cnt - CNT_ONE;
    end

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          sh_nxt    = fifo_dout;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_cnt == '0) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_cnt == '0) begin
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            idx_nxt = bit_idx + 3'd1;
            cnt_nxt = CNT_RELOAD;
            sh_nxt  = {1'b0, shreg[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sh_nxt    = fifo_dout;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Bit timer and index restart on every state change, including STOP -> START.
    if (state_nxt != state) begin
      cnt_nxt = CNT_RELOAD;
      idx_nxt = 3'd0;
    end

    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = sh_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase

    // Busy after this edge: a frame continues, or the FIFO still holds a byte.
    busy_nxt = (state_nxt != ST_IDLE) || fifo_push ||
               (fifo_count > {{(FCW-1){1'b0}}, fifo_pop});
  end

  // State register and registered line/busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= sh_nxt;
      o_tx    <= tx_nxt;
      o_busy  <= busy_nxt;
    end
  end

endmodule
